// File: rtl/niu32_io_responder.sv
// niu32_io_responder: memory-mapped board I/O responder (HEX, LEDs, keys, switches) for the Niu32 data bus
module niu32_io_responder #(
  parameter int                   WORD_SIZE       = 32,
  parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
  parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
  parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120,
  parameter int                   DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 io_hit,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  input  logic [3:0]           KEY,
  input  logic [9:0]           SWITCH,
  output logic [15:0]          HEXout,
  output logic [9:0]           LEDR,
  output logic [7:0]           LEDG
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw;
  logic acc, st, ld;
  logic [15:0] hex_q, hex_d;
  logic [9:0] ledr_q, ledr_d;
  logic [7:0] ledg_q, ledg_d;
  logic [9:0] sw_s1_q, sw_sync_q;
  logic [3:0] key_s1_q, key_sync_q;
  logic [3:0] key_db_q, key_db_d;
  logic [3:0] key_flag_q, key_flag_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic resp_valid_q;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d, rd_mux;
  logic unused_wdata;
  assign unused_wdata = ^req_wdata[WORD_SIZE-1:16];
  assign hit_hex  = req_addr == ADDR_HEX;
  assign hit_ledr = req_addr == ADDR_LEDR;
  assign hit_ledg = req_addr == ADDR_LEDG;
  assign hit_key  = req_addr == ADDR_KEY;
  assign hit_sw   = req_addr == ADDR_SWITCH;
  assign io_hit   = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw;
  assign acc = req_valid & io_hit;
  assign st  = acc & req_we;
  assign ld  = acc & ~req_we;
  assign HEXout     = hex_q;
  assign LEDR       = ledr_q;
  assign LEDG       = ledg_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  // Output registers take store data; load data is muxed from current state at the accept edge
  always_comb begin
    hex_d  = (st & hit_hex)  ? req_wdata[15:0] : hex_q;
    ledr_d = (st & hit_ledr) ? req_wdata[9:0]  : ledr_q;
    ledg_d = (st & hit_ledg) ? req_wdata[7:0]  : ledg_q;
    rd_mux = hit_hex  ? {{(WORD_SIZE-16){1'b0}}, hex_q} :
             hit_ledr ? {{(WORD_SIZE-10){1'b0}}, ledr_q} :
             hit_ledg ? {{(WORD_SIZE-8){1'b0}}, ledg_q} :
             hit_key  ? {{(WORD_SIZE-8){1'b0}}, key_flag_q, key_db_q} :
             hit_sw   ? {{(WORD_SIZE-10){1'b0}}, sw_sync_q} : '0;
    resp_rdata_d = ld ? rd_mux : resp_rdata_q;
  end
  // Per-key debounce: a differing synced bit must persist DEBOUNCE_CYCLES samples before key_db follows it
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (key_sync_q[i] == key_db_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      key_db_d[i] = (key_sync_q[i] != key_db_q[i] && cnt_q[i] == CNT_MAX) ? key_sync_q[i] : key_db_q[i];
    end
    key_flag_d = (key_flag_q & ~{4{ld & hit_key}}) | (key_db_d & ~key_db_q);
  end
  // State registers; a store coinciding with reset is discarded along with its acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q        <= '0;
      ledr_q       <= '0;
      ledg_q       <= '0;
      sw_s1_q      <= '0;
      sw_sync_q    <= '0;
      key_s1_q     <= '0;
      key_sync_q   <= '0;
      key_db_q     <= '0;
      key_flag_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      hex_q        <= hex_d;
      ledr_q       <= ledr_d;
      ledg_q       <= ledg_d;
      sw_s1_q      <= SWITCH;
      sw_sync_q    <= sw_s1_q;
      key_s1_q     <= ~KEY;
      key_sync_q   <= key_s1_q;
      key_db_q     <= key_db_d;
      key_flag_q   <= key_flag_d;
      resp_valid_q <= acc;
      resp_rdata_q <= resp_rdata_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_niu32_io_responder.sv
// tb_niu32_io_responder: directed vector table plus key debounce and reset sequences
module tb_niu32_io_responder;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic io_hit, resp_valid;
  logic [31:0] resp_rdata;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SWITCH = 10'h2A3;
  logic [15:0] HEXout;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic        v, we;
    logic [31:0] addr, wdata;
    logic        hit, ack;
    logic [31:0] rd;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
  } vec_t;
  vec_t vt [14];
  niu32_io_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .io_hit(io_hit),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .KEY(KEY),
    .SWITCH(SWITCH), .HEXout(HEXout), .LEDR(LEDR), .LEDG(LEDG)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic op(input string name, input logic v, input logic we, input logic [31:0] a,
                    input logic [31:0] d, input logic eh, input logic ea, input logic [31:0] er);
    @(negedge clk);
    req_valid = v;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    #1 chk({name, " io_hit"}, 32'(io_hit), 32'(eh));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({name, " resp_valid"}, 32'(resp_valid), 32'(ea));
    if (ea && !we) chk({name, " rdata"}, resp_rdata, er);
  endtask
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    vt[0]  = '{1, 1, 32'hFFFF0000, 32'h0000ABCD, 1, 1, 32'h0, 16'hABCD, 10'h000, 8'h00};
    vt[1]  = '{1, 1, 32'hFFFF0020, 32'h000003FF, 1, 1, 32'h0, 16'hABCD, 10'h3FF, 8'h00};
    vt[2]  = '{1, 1, 32'hFFFF0040, 32'h000000A5, 1, 1, 32'h0, 16'hABCD, 10'h3FF, 8'hA5};
    vt[3]  = '{1, 0, 32'hFFFF0000, 32'h0,        1, 1, 32'h0000ABCD, 16'hABCD, 10'h3FF, 8'hA5};
    vt[4]  = '{1, 0, 32'hFFFF0020, 32'h0,        1, 1, 32'h000003FF, 16'hABCD, 10'h3FF, 8'hA5};
    vt[5]  = '{1, 0, 32'hFFFF0040, 32'h0,        1, 1, 32'h000000A5, 16'hABCD, 10'h3FF, 8'hA5};
    vt[6]  = '{1, 0, 32'hFFFF0120, 32'h0,        1, 1, 32'h000002A3, 16'hABCD, 10'h3FF, 8'hA5};
    vt[7]  = '{1, 0, 32'h00000100, 32'h0,        0, 0, 32'h0, 16'hABCD, 10'h3FF, 8'hA5};
    vt[8]  = '{1, 1, 32'hFFFF0100, 32'hFFFFFFFF, 1, 1, 32'h0, 16'hABCD, 10'h3FF, 8'hA5};
    vt[9]  = '{1, 1, 32'hFFFF0120, 32'h0,        1, 1, 32'h0, 16'hABCD, 10'h3FF, 8'hA5};
    vt[10] = '{1, 0, 32'hFFFF0100, 32'h0,        1, 1, 32'h00000000, 16'hABCD, 10'h3FF, 8'hA5};
    vt[11] = '{1, 1, 32'hFFFF0000, 32'hFFFF1234, 1, 1, 32'h0, 16'h1234, 10'h3FF, 8'hA5};
    vt[12] = '{1, 0, 32'hFFFF0000, 32'h0,        1, 1, 32'h00001234, 16'h1234, 10'h3FF, 8'hA5};
    vt[13] = '{0, 1, 32'hFFFF0004, 32'h00000055, 0, 0, 32'h0, 16'h1234, 10'h3FF, 8'hA5};
    wait_neg(3);
    reset = 1'b0;
    #1;
    chk("rst HEXout", 32'(HEXout), 32'h0);
    chk("rst LEDR", 32'(LEDR), 32'h0);
    chk("rst LEDG", 32'(LEDG), 32'h0);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 14; i++) begin
      op($sformatf("vec%0d", i), vt[i].v, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].hit, vt[i].ack, vt[i].rd);
      chk($sformatf("vec%0d HEXout", i), 32'(HEXout), 32'(vt[i].hex));
      chk($sformatf("vec%0d LEDR", i), 32'(LEDR), 32'(vt[i].ledr));
      chk($sformatf("vec%0d LEDG", i), 32'(LEDG), 32'(vt[i].ledg));
    end
    @(negedge clk);
    KEY[2] = 1'b0;
    wait_neg(D + 4);
    op("key2 held", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000044);
    op("key2 reread", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000004);
    @(negedge clk);
    KEY[2] = 1'b1;
    wait_neg(D + 4);
    op("key2 released", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000000);
    @(negedge clk);
    KEY[0] = 1'b0;
    wait_neg(D - 2);
    KEY[0] = 1'b1;
    wait_neg(D + 4);
    op("key0 glitch", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000000);
    @(negedge clk);
    KEY[1] = 1'b0;
    wait_neg(D);
    op("key1 coincident", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000000);
    op("key1 after", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000022);
    op("key1 cleared", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000002);
    @(negedge clk);
    KEY[1] = 1'b1;
    SWITCH = 10'h15C;
    wait_neg(2);
    op("switch new", 1, 0, 32'hFFFF0120, 0, 1, 1, 32'h0000015C);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'hFFFF0020;
    req_wdata = 32'h00000155;
    #1 chk("reset io_hit", 32'(io_hit), 32'h1);
    @(posedge clk);
    #1;
    chk("reset-store LEDR", 32'(LEDR), 32'h0);
    chk("reset-store HEXout", 32'(HEXout), 32'h0);
    chk("reset-store LEDG", 32'(LEDG), 32'h0);
    chk("reset-store resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset resp_valid", 32'(resp_valid), 32'h0);
    chk("post-reset LEDR", 32'(LEDR), 32'h0);
    wait_neg(D + 4);
    op("post-reset key", 1, 0, 32'hFFFF0100, 0, 1, 1, 32'h00000000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
